// File: rtl/minterm_eval_pkg.sv
// Shared types and width helpers for the minterm_eval block.
package minterm_eval_pkg;

    typedef enum logic {IDLE, SWEEP} state_t;

    function automatic int unsigned mask_width(input int unsigned n);
        return 32'd1 << n;
    endfunction

    function automatic int unsigned count_width(input int unsigned n);
        return n + 32'd1;
    endfunction

endpackage

// File: rtl/minterm_eval_if.sv
// Control/result bundle for minterm_eval. MINTERM_EVAL_POS_EN adds pos_mode.
interface minterm_eval_if #(parameter int N_IN = 3);
    import minterm_eval_pkg::*;

    localparam int MW = int'(mask_width(N_IN));
    localparam int CW = int'(count_width(N_IN));

    logic          load;
    logic [MW-1:0] mask_in;
    logic          in_valid;
    logic [N_IN-1:0] in_bits;
    logic          start;
`ifdef MINTERM_EVAL_POS_EN
    logic          pos_mode;
`endif
    logic          s_out;
    logic          out_valid;
    logic [N_IN-1:0] out_idx;
    logic          busy;
    logic          done;
    logic [CW-1:0] ones_count;

    modport master (
`ifdef MINTERM_EVAL_POS_EN
        output pos_mode,
`endif
        output load, mask_in, in_valid, in_bits, start,
        input  s_out, out_valid, out_idx, busy, done, ones_count
    );

    modport slave (
`ifdef MINTERM_EVAL_POS_EN
        input  pos_mode,
`endif
        input  load, mask_in, in_valid, in_bits, start,
        output s_out, out_valid, out_idx, busy, done, ones_count
    );

endinterface

// File: rtl/minterm_lut.sv
// Mask-indexed function lookup; pos inverts the selected bit (maxterm form).
module minterm_lut
    import minterm_eval_pkg::*;
#(
    parameter int N_IN = 3
) (
    input  logic [int'(mask_width(N_IN))-1:0] mask,
    input  logic [N_IN-1:0]                   idx,
    input  logic                              pos,
    output logic                              s
);

    always_comb begin
        s = mask[idx] ^ pos;
    end

endmodule

// File: rtl/minterm_eval.sv
// Loadable N_IN-input minterm function with single evaluation and exhaustive sweep.
// Optional maxterm mode enabled by defining MINTERM_EVAL_POS_EN.
module minterm_eval
    import minterm_eval_pkg::*;
#(
    parameter int N_IN = 3
) (
    input logic            clk,
    input logic            rst,
    minterm_eval_if.slave  bus
);

    localparam int MW = int'(mask_width(N_IN));
    localparam int CW = int'(count_width(N_IN));

    state_t          state;
    logic [MW-1:0]   mask;
    logic [CW-1:0]   cnt;
    logic            pos_q;
    logic [N_IN-1:0] lut_idx;
    logic            lut_s;

`ifndef MINTERM_EVAL_POS_EN
    assign pos_q = 1'b0;
`endif

    // One lookup serves both paths: the sweep counter owns it while sweeping.
    always_comb begin
        lut_idx = (state == SWEEP) ? cnt[N_IN-1:0] : bus.in_bits;
    end

    minterm_lut #(.N_IN(N_IN)) u_lut (
        .mask (mask),
        .idx  (lut_idx),
        .pos  (pos_q),
        .s    (lut_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            mask           <= '0;
            cnt            <= '0;
`ifdef MINTERM_EVAL_POS_EN
            pos_q          <= 1'b0;
`endif
            bus.s_out      <= 1'b0;
            bus.out_valid  <= 1'b0;
            bus.out_idx    <= '0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.ones_count <= '0;
        end else begin
            bus.out_valid <= 1'b0;
            bus.done      <= 1'b0;
            case (state)
                IDLE: begin
                    bus.busy <= 1'b0;
                    if (bus.load) begin
                        mask  <= bus.mask_in;
`ifdef MINTERM_EVAL_POS_EN
                        pos_q <= bus.pos_mode;
`endif
                    end
                    if (bus.start) begin
                        state          <= SWEEP;
                        cnt            <= '0;
                        bus.ones_count <= '0;
                        bus.busy       <= 1'b1;
                    end else if (bus.in_valid) begin
                        bus.out_valid <= 1'b1;
                        bus.out_idx   <= bus.in_bits;
                        bus.s_out     <= lut_s;
                    end
                end
                SWEEP: begin
                    bus.out_valid  <= 1'b1;
                    bus.out_idx    <= cnt[N_IN-1:0];
                    bus.s_out      <= lut_s;
                    bus.ones_count <= bus.ones_count + CW'(lut_s);
                    cnt            <= cnt + CW'(1);
                    if (cnt == CW'(MW - 1)) begin
                        bus.done <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_minterm_eval.sv
// Scoreboard bench for minterm_eval: N_IN=3 and N_IN=2 instances.
module tb_minterm_eval;

    typedef struct {
        int unsigned idx;
        logic        s;
        logic        done;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    exp_t q3[$];
    exp_t q2[$];

    always #5 clk = ~clk;

    minterm_eval_if #(.N_IN(3)) if3 ();
    minterm_eval_if #(.N_IN(2)) if2 ();

    minterm_eval #(.N_IN(3)) dut3 (.clk(clk), .rst(rst), .bus(if3));
    minterm_eval #(.N_IN(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push3(input int unsigned idx, input logic s, input logic d);
        exp_t e;
        e.idx = idx; e.s = s; e.done = d;
        q3.push_back(e);
    endtask

    // Monitor for the N_IN=3 instance
    always @(negedge clk) begin
        if (if3.out_valid) begin
            if (q3.size() == 0) begin
                chk("n3_unexpected_result", 32'(if3.out_idx), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = q3.pop_front();
                chk("n3_out_idx", 32'(if3.out_idx), e.idx);
                chk("n3_s_out",   32'(if3.s_out),   32'(e.s));
                chk("n3_done",    32'(if3.done),    32'(e.done));
            end
        end else if (if3.done) begin
            chk("n3_done_without_valid", 32'(if3.done), 32'd0);
        end
    end

    // Monitor for the N_IN=2 instance
    always @(negedge clk) begin
        if (if2.out_valid) begin
            if (q2.size() == 0) begin
                chk("n2_unexpected_result", 32'(if2.out_idx), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = q2.pop_front();
                chk("n2_out_idx", 32'(if2.out_idx), e.idx);
                chk("n2_s_out",   32'(if2.s_out),   32'(e.s));
                chk("n2_done",    32'(if2.done),    32'(e.done));
            end
        end
    end

    task automatic load3(input logic [7:0] m, input logic pm);
        if3.load = 1'b1; if3.mask_in = m;
`ifdef MINTERM_EVAL_POS_EN
        if3.pos_mode = pm;
`endif
        tick();
        if3.load = 1'b0;
`ifdef MINTERM_EVAL_POS_EN
        if3.pos_mode = 1'b0;
`endif
        if (pm) begin end
    endtask

    // Issue start; returns just after the edge that sampled it.
    task automatic start3();
        if3.start = 1'b1;
        tick();
        if3.start = 1'b0;
    endtask

    task automatic push_seq3(input logic [7:0] s_seq);
        logic [7:0] v;
        v = s_seq;
        for (int i = 0; i < 8; i++) push3(i, v[i], i == 7);
    endtask

    task automatic wait_done3(input string name, input int unsigned ones);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (if3.done) seen = 1'b1;
        end
        chk({name, "_done_seen"}, 32'(seen), 32'd1);
        chk({name, "_busy_on_done"}, 32'(if3.busy), 32'd1);
        @(negedge clk);
        chk({name, "_busy_after"}, 32'(if3.busy), 32'd0);
        chk({name, "_ones_count"}, 32'(if3.ones_count), ones);
        chk({name, "_done_after"}, 32'(if3.done), 32'd0);
    endtask

    initial begin
        logic [3:0] exp2;
        if3.load = 0; if3.mask_in = '0; if3.in_valid = 0; if3.in_bits = '0; if3.start = 0;
        if2.load = 0; if2.mask_in = '0; if2.in_valid = 0; if2.in_bits = '0; if2.start = 0;
`ifdef MINTERM_EVAL_POS_EN
        if3.pos_mode = 0; if2.pos_mode = 0;
`endif
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_s_out",      32'(if3.s_out),      32'd0);
        chk("rst_out_valid",  32'(if3.out_valid),  32'd0);
        chk("rst_out_idx",    32'(if3.out_idx),    32'd0);
        chk("rst_busy",       32'(if3.busy),       32'd0);
        chk("rst_done",       32'(if3.done),       32'd0);
        chk("rst_ones_count", 32'(if3.ones_count), 32'd0);

        // Sweep of SoP 1,2,5,6: s sequence idx0..7 = 0,1,1,0,0,1,1,0 (bit i = idx i)
        tick();
        load3(8'b0110_0110, 1'b0);
        push_seq3(8'b0110_0110);
        start3();
        wait_done3("sweep66", 4);

        // N_IN=2, mask 0010 (a'b): in 00,01,10,11 -> 0,1,0,0
        tick();
        if2.load = 1'b1; if2.mask_in = 4'b0010;
        tick();
        if2.load = 1'b0;
        exp2 = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            e.idx = i; e.s = exp2[i]; e.done = 1'b0;
            q2.push_back(e);
            if2.in_valid = 1'b1; if2.in_bits = 2'(i);
            tick();
        end
        if2.in_valid = 1'b0;

        // Same-cycle load uses the old mask
        load3(8'h00, 1'b0);
        if3.load = 1'b1; if3.mask_in = 8'hFF; if3.in_valid = 1'b1; if3.in_bits = 3'd3;
        push3(3, 1'b0, 1'b0);
        tick();
        if3.load = 1'b0;
        push3(3, 1'b1, 1'b0);
        tick();
        if3.in_valid = 1'b0;
        tick();
        push_seq3(8'hFF);
        start3();
        wait_done3("sweepff", 8);

        // start/load/in_valid during a sweep are ignored
        tick();
        load3(8'b0110_0110, 1'b0);
        push_seq3(8'b0110_0110);
        start3();
        repeat (5) tick();
        if3.start = 1'b1; if3.load = 1'b1; if3.mask_in = 8'h00;
        if3.in_valid = 1'b1; if3.in_bits = 3'd0;
        tick();
        if3.start = 1'b0; if3.load = 1'b0; if3.in_valid = 1'b0;
        wait_done3("sweep_ign", 4);
        repeat (3) tick();
        if3.in_valid = 1'b1; if3.in_bits = 3'd1;
        push3(1, 1'b1, 1'b0);
        tick();
        if3.in_valid = 1'b0;
        tick();

        // Reset during result 5 aborts the sweep
        for (int i = 0; i < 6; i++) push3(i, (8'h66 >> i) & 1, 1'b0);
        start3();
        repeat (6) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("abort_out_valid",  32'(if3.out_valid),  32'd0);
        chk("abort_s_out",      32'(if3.s_out),      32'd0);
        chk("abort_out_idx",    32'(if3.out_idx),    32'd0);
        chk("abort_busy",       32'(if3.busy),       32'd0);
        chk("abort_done",       32'(if3.done),       32'd0);
        chk("abort_ones_count", 32'(if3.ones_count), 32'd0);
        tick();
        push_seq3(8'h00);
        start3();
        wait_done3("sweep_cleared", 0);

`ifdef MINTERM_EVAL_POS_EN
        // Maxterm form: s = ~mask bit -> 1,0,0,1,1,0,0,1
        tick();
        load3(8'b0110_0110, 1'b1);
        push_seq3(8'b1001_1001);
        start3();
        wait_done3("sweep_pos", 4);
`endif

        repeat (4) tick();
        chk("n3_queue_empty", 32'(q3.size()), 32'd0);
        chk("n2_queue_empty", 32'(q2.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/minterm_eval.md
Name: minterm_eval

Overview:
- Parametrised, clocked successor to the fixed 2- and 3-input SoP function blocks.
- Holds an N_IN-input Boolean function as a loadable minterm mask register.
- Evaluates single input vectors on request (registered, 1-cycle latency).
- Sweep mode enumerates all 2^N_IN input combinations in hardware, emitting one result per cycle plus a count of true minterms. This replaces exhaustive testbench stimulus loops.

Parameters:
- N_IN, 3, number of function inputs (1..8); mask width is 2^N_IN.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- load  in  1  write mask_in into the mask register
- mask_in  in  2^N_IN  bit k=1 means minterm k is in the SoP
- in_valid  in  1  request evaluation of in_bits
- in_bits  in  N_IN  input vector; MSB is the first variable (a), index = in_bits
- start  in  1  begin exhaustive sweep
- s_out  out  1  function value
- out_valid  out  1  s_out/out_idx valid this cycle
- out_idx  out  N_IN  input index that produced s_out
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse on the final sweep result
- ones_count  out  N_IN+1  number of 1 results in the last/current sweep

Behaviour:
- Reset (rst sampled high at a clk edge):
  - Mask cleared to 0; FSM to IDLE.
  - s_out, out_valid, out_idx, busy, done, ones_count all 0.
  - Applies mid-sweep: the sweep is aborted with no done pulse.
- FSM states IDLE, SWEEP.
- IDLE:
  - load=1 → mask <= mask_in.
  - in_valid=1 → next cycle: out_valid=1, out_idx=in_bits, s_out=mask[in_bits].
  - The evaluation uses the mask value before any same-cycle load; the new mask is visible from the following cycle.
  - start=1 → SWEEP, counter <= 0, ones_count <= 0. in_valid in the same cycle as start is ignored.
- SWEEP, each cycle:
  - Registered out_valid=1, out_idx=cnt, s_out=mask[cnt].
  - ones_count += mask[cnt].
  - cnt += 1.
- Sweep end:
  - When cnt == 2^N_IN-1, that result cycle also asserts done=1; FSM returns to IDLE.
  - busy=1 from the cycle after start through the done cycle inclusive.
  - Latency: first result 1 cycle after start is sampled; done 2^N_IN cycles after start.
- During SWEEP, load, in_valid and start are ignored; the mask is frozen.
- ones_count holds its value in IDLE until the next start. Its width N_IN+1 covers the all-ones mask (2^N_IN) without wrap.
- Counter width: N_IN+1 bits internally, so there is no wrap ambiguity at the last index.
- out_valid is 0 on any cycle without a result.

Optional Feature:
- MINTERM_EVAL_POS_EN defined:
  - Adds input pos_mode (1 bit), sampled with load and stored alongside the mask.
  - When stored pos_mode=1, the mask lists maxterms: s_out = ~mask[idx], and ones_count counts the resulting 1s.
- Undefined: port absent, SoP only.

Decomposition:
- minterm_eval_pkg holds:
  - the state enum {IDLE, SWEEP};
  - a function returning mask width 2^n;
  - a function returning count width n+1.
- Sub-module minterm_lut: combinational mask-indexed select (mask, idx, pos) → s. It is shared by the evaluation and sweep paths.

Test Plan:
- N_IN=3, load mask 8'b01100110 (SoP 1,2,5,6), start → s_out sequence 0,1,1,0,0,1,1,0 on idx 0..7; done on 8th result; ones_count=4; busy low the next cycle.
- N_IN=2 instance, mask 4'b0010 (a'b); in_valid with in_bits 00,01,10,11 → s_out 0,1,0,0, each 1 cycle later with matching out_idx.
- Same cycle load mask=8'hFF and in_valid idx=3 with old mask 8'h00 → s_out=0; next in_valid idx=3 → 1. Then sweep → ones_count=8, no wrap.
- start again at result 4 of a sweep, plus load and in_valid during the sweep → all ignored; sequence and mask unchanged; exactly one done.
- rst asserted at result 5 of a sweep → next cycle all outputs 0, mask 0, no done. A subsequent sweep gives ones_count=0.
- With MINTERM_EVAL_POS_EN: load mask 8'b01100110 with pos_mode=1, sweep → s_out 1,0,0,1,1,0,0,1; ones_count=4.
